video_sync_receiver: RTL and testbench
======================================

VIDEO_SYNC_RECEIVER -- requirements
Module: video_sync_receiver

Interface
REQ-001 SHALL have parameter POS_W, default 9: width of positions and measured timing values.
REQ-002 SHALL have parameter LOCK_FRAMES, default 2: number of consecutive matching frames required to assert locked (legal range 2..15).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports hsync, vsync, display_on, input, 1 each: active-high, sampled on clk.
REQ-006 SHALL have ports red, green, blue, input, 8 each: pixel data qualified by display_on.
REQ-007 SHALL have ports x, y, output, POS_W each: recovered active-area pixel position.
REQ-008 SHALL have port pixel_valid, output, 1: x, y and rgb outputs carry an active pixel.
REQ-009 SHALL have ports red_out, green_out, blue_out, output, 8 each: pixel data aligned with x and y.
REQ-010 SHALL have port frame_start, output, 1: single-cycle pulse at each frame boundary.
REQ-011 SHALL have ports h_total, v_total, h_active, v_active, output, POS_W each: measured timing values.
REQ-012 SHALL have port locked, output, 1: timing stable.
REQ-013 SHALL have port err_count, output, 8: count of lock losses.

Function
REQ-014 SHALL register all inputs once (stage 1) and detect rising edges of hsync and vsync against the previous stage-1 sample.
REQ-015 SHALL make x, y, pixel_valid and rgb_out valid 2 clocks after the corresponding input sample.
REQ-016 SHALL reset x to 0 on each hsync rise and increment it after each active pixel.
REQ-017 SHALL make the first active pixel of a line x=0.
REQ-018 SHALL increment y once per line containing at least one active pixel, at that line's hsync rise.
REQ-019 SHALL reset y to 0 on vsync rise.
REQ-020 SHALL set h_total to the number of clocks between consecutive hsync rises, updated at each hsync rise.
REQ-021 SHALL set h_active to the active-pixel count of the most recently completed line, updated at each hsync rise.
REQ-022 SHALL set v_total to the number of hsync rises between consecutive vsync rises.
REQ-023 SHALL set v_active to the number of lines containing active pixels between consecutive vsync rises.
REQ-024 SHALL update v_total and v_active at each vsync rise.
REQ-025 SHALL saturate all counters and measurements at 2^POS_W-1; they never wrap.
REQ-026 SHALL, when hsync and vsync rise in the same cycle, count the completed line into the frame being closed before the frame counters clear.
REQ-027 SHALL pulse frame_start for exactly 1 cycle, 1 cycle after a vsync rise is detected.
REQ-028 SHALL implement lock FSM state SEARCH: wait for the first vsync rise, then go to MEASURE.
REQ-029 SHALL implement lock FSM state MEASURE: at each vsync rise, compare the frame's h_total/v_total with the previous frame's.
REQ-030 SHALL in MEASURE increment a match counter on a match, and set the match counter to 1 on a mismatch.
REQ-031 SHALL in MEASURE go to LOCKED when the match counter reaches LOCK_FRAMES-1.
REQ-032 SHALL implement lock FSM state LOCKED: any hsync period differing from the stored h_total, or any frame whose v_total differs from the stored v_total, goes to SEARCH.
REQ-033 SHALL increment err_count on each LOCKED-to-SEARCH transition, saturating at 255.
REQ-034 SHALL assert locked only in LOCKED, registered.
REQ-035 SHALL force pixel_valid=0 while locked=0; x and y keep counting.
REQ-036 SHALL treat display_on=1 outside any hsync-bounded line (before the first hsync rise) as not active.

Reset
REQ-037 SHALL drive on reset: FSM to SEARCH; x, y, all measurements, err_count and the match counter to 0; pixel_valid, frame_start and locked to 0; rgb_out to 0; edge-detect history to 0.
REQ-038 SHALL abandon all partial measurements when reset is asserted mid-frame; after release, lock requires fresh full frames.

Structure
REQ-039 SHALL place POS_W default, FSM state encodings and the saturation limit in the shared video include/package used by video_sync_generator.
REQ-040 SHALL contain one sub-module, video_timing_measure: the h/v period and active counters with saturation.
REQ-041 SHALL keep edge detection, the lock FSM and the pixel pipeline in the top module.

Verification
REQ-042 SHALL cover nominal timing: bench timing H_TOTAL=309, V_TOTAL=262, 256x240 active, hsync/vsync active-high -> h_total=309, v_total=262, h_active=256, v_active=240; locked rises at the 3rd vsync rise after reset (LOCK_FRAMES=2).
REQ-043 SHALL cover pixel alignment: inject a pixel with red=8'hA5 at active (17,33) -> 2 cycles later x=17, y=33, red_out=8'hA5, pixel_valid=1.
REQ-044 SHALL cover a timing glitch: once locked, shorten one line to 300 clocks -> locked=0 within 1 cycle of that hsync rise, err_count=1, relock after 2 good frames.
REQ-045 SHALL cover simultaneous edges: hsync and vsync rise in the same cycle -> v_total still 262, y=0, frame_start pulses once.
REQ-046 SHALL cover saturation: hold hsync low for 600 clocks -> h_total=511, no wrap, locked=0.
REQ-047 SHALL cover reset mid-frame: assert reset at line 100 for 1 cycle -> all outputs 0; first valid v_total=262 only after 2 subsequent vsync rises.

Source files
------------

// File: rtl/video_sync_pkg.sv
// rtl/video_sync_pkg.sv - shared video timing defaults, lock FSM encodings and saturation limit
package video_sync_pkg;

  localparam int POS_W_DEFAULT       = 9;
  localparam int LOCK_FRAMES_DEFAULT = 2;
  localparam logic [7:0] ERR_MAX     = 8'hFF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_t;

  // Largest value a width-bit counter may hold before it sticks.
  function automatic int unsigned sat_limit(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/video_timing_measure.sv
// rtl/video_timing_measure.sv - saturating line/frame period and active-pixel counters
module video_timing_measure
  import video_sync_pkg::*;
#(
  parameter int POS_W = POS_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hs_rise,
  input  logic             vs_rise,
  input  logic             active,
  output logic [POS_W-1:0] h_total,
  output logic [POS_W-1:0] h_active,
  output logic [POS_W-1:0] v_total,
  output logic [POS_W-1:0] v_active,
  output logic [POS_W-1:0] h_meas,
  output logic [POS_W-1:0] v_meas,
  output logic [POS_W-1:0] line_count
);

  localparam logic [POS_W-1:0] SAT_MAX = POS_W'(sat_limit(POS_W));
  localparam logic [POS_W-1:0] ONE     = POS_W'(1);

  logic [POS_W-1:0] h_cnt, ha_cnt, v_cnt, va_cnt, va_meas;

  // Values that close at this cycle's edges; a line ending together with the
  // frame is counted into the frame being closed.
  always_comb begin
    h_meas     = h_cnt;
    line_count = ha_cnt;
    v_meas     = (hs_rise && v_cnt != SAT_MAX) ? v_cnt + ONE : v_cnt;
    va_meas    = (hs_rise && ha_cnt != '0 && va_cnt != SAT_MAX) ? va_cnt + ONE : va_cnt;
  end

  // Running counters and the latched measurements.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt    <= '0;
      ha_cnt   <= '0;
      v_cnt    <= '0;
      va_cnt   <= '0;
      h_total  <= '0;
      h_active <= '0;
      v_total  <= '0;
      v_active <= '0;
    end else begin
      if (hs_rise) begin
        h_total  <= h_cnt;
        h_active <= ha_cnt;
        h_cnt    <= ONE;
        ha_cnt   <= {{(POS_W-1){1'b0}}, active};
      end else begin
        if (h_cnt != SAT_MAX) h_cnt <= h_cnt + ONE;
        if (active && ha_cnt != SAT_MAX) ha_cnt <= ha_cnt + ONE;
      end
      if (vs_rise) begin
        v_total  <= v_meas;
        v_active <= va_meas;
        v_cnt    <= '0;
        va_cnt   <= '0;
      end else begin
        v_cnt    <= v_meas;
        va_cnt   <= va_meas;
      end
    end
  end

endmodule

// File: rtl/video_sync_receiver.sv
// rtl/video_sync_receiver.sv - sync edge detect, timing lock FSM and 2-stage pixel pipeline
module video_sync_receiver
  import video_sync_pkg::*;
#(
  parameter int POS_W       = POS_W_DEFAULT,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             display_on,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y,
  output logic             pixel_valid,
  output logic [7:0]       red_out,
  output logic [7:0]       green_out,
  output logic [7:0]       blue_out,
  output logic             frame_start,
  output logic [POS_W-1:0] h_total,
  output logic [POS_W-1:0] v_total,
  output logic [POS_W-1:0] h_active,
  output logic [POS_W-1:0] v_active,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam logic [POS_W-1:0] SAT_MAX    = POS_W'(sat_limit(POS_W));
  localparam logic [3:0]       MATCH_GOAL = 4'(LOCK_FRAMES - 1);

  logic             hs1, vs1, de1, hs2, vs2, seen_line;
  logic [7:0]       r1, g1, b1;
  logic             hs_rise, vs_rise, active;
  logic [POS_W-1:0] y_cnt, x_cur, y_cur;
  logic [POS_W-1:0] h_meas, v_meas, line_count, h_cmp, ref_h, ref_v;
  logic             frame_match, ref_load, lost;
  logic [3:0]       match_cnt, match_nxt;
  lock_state_t      state, state_nxt;

  // A pixel only counts once a line has been opened by an hsync rise.
  assign hs_rise     = hs1 & ~hs2;
  assign vs_rise     = vs1 & ~vs2;
  assign active      = de1 & (seen_line | hs_rise);
  assign x_cur       = hs_rise ? '0 : line_count;
  assign h_cmp       = hs_rise ? h_meas : h_total;
  assign frame_match = (h_cmp == ref_h) && (v_meas == ref_v);

  // Row for the current stage-1 sample; vsync rise overrides a line advance.
  always_comb begin
    y_cur = y_cnt;
    if (vs_rise) y_cur = '0;
    else if (hs_rise && line_count != '0 && y_cnt != SAT_MAX) y_cur = y_cnt + POS_W'(1);
  end

  video_timing_measure #(.POS_W(POS_W)) u_measure (
    .clk        (clk),
    .reset      (reset),
    .hs_rise    (hs_rise),
    .vs_rise    (vs_rise),
    .active     (active),
    .h_total    (h_total),
    .h_active   (h_active),
    .v_total    (v_total),
    .v_active   (v_active),
    .h_meas     (h_meas),
    .v_meas     (v_meas),
    .line_count (line_count)
  );

  // Stage 1 input registers, edge history and row counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      {hs1, vs1, de1, hs2, vs2, seen_line} <= '0;
      {r1, g1, b1} <= '0;
      y_cnt <= '0;
    end else begin
      hs1 <= hsync;
      vs1 <= vsync;
      de1 <= display_on;
      r1  <= red;
      g1  <= green;
      b1  <= blue;
      hs2 <= hs1;
      vs2 <= vs1;
      if (hs_rise) seen_line <= 1'b1;
      y_cnt <= y_cur;
    end
  end

  // Stage 2 output registers for the pixel stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      pixel_valid <= 1'b0;
      {red_out, green_out, blue_out} <= '0;
      frame_start <= 1'b0;
    end else begin
      x <= x_cur;
      y <= y_cur;
      pixel_valid <= active & locked;
      red_out   <= r1;
      green_out <= g1;
      blue_out  <= b1;
      frame_start <= vs_rise;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_SEARCH;
    else       state <= state_nxt;
  end

  // Lock FSM next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEARCH:  if (vs_rise) state_nxt = ST_MEASURE;
      ST_MEASURE: if (vs_rise && frame_match && match_cnt >= MATCH_GOAL) state_nxt = ST_LOCKED;
      ST_LOCKED:  if ((hs_rise && h_meas != ref_h) || (vs_rise && v_meas != ref_v))
                    state_nxt = ST_SEARCH;
      default:    state_nxt = ST_SEARCH;
    endcase
  end

  // Lock FSM outputs: reference capture, run length of matching frames, loss flag.
  always_comb begin
    match_nxt = match_cnt;
    ref_load  = 1'b0;
    lost      = 1'b0;
    case (state)
      ST_SEARCH: begin
        match_nxt = 4'd0;
        ref_load  = vs_rise;
      end
      ST_MEASURE: if (vs_rise) begin
        ref_load  = 1'b1;
        match_nxt = !frame_match ? 4'd1 : (match_cnt == 4'hF ? 4'hF : match_cnt + 4'd1);
      end
      ST_LOCKED: lost = (state_nxt == ST_SEARCH);
      default: match_nxt = 4'd0;
    endcase
  end

  // Lock bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_cnt <= 4'd0;
      ref_h     <= '0;
      ref_v     <= '0;
      locked    <= 1'b0;
      err_count <= 8'd0;
    end else begin
      match_cnt <= match_nxt;
      if (ref_load) begin
        ref_h <= h_cmp;
        ref_v <= v_meas;
      end
      locked <= (state_nxt == ST_LOCKED);
      if (lost && err_count != ERR_MAX) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_video_sync_receiver.sv
// tb/tb_video_sync_receiver.sv - directed self-checking bench for video_sync_receiver
module tb_video_sync_receiver;

  localparam int PW = 9;

  logic          clk, reset, hsync, vsync, display_on;
  logic [7:0]    red, green, blue;
  logic [PW-1:0] x, y, h_total, v_total, h_active, v_active;
  logic          pixel_valid, frame_start, locked;
  logic [7:0]    red_out, green_out, blue_out, err_count;

  int compared = 0;
  int failed   = 0;
  int hc, vc, hlen, vs_off;

  typedef struct {
    int         v;
    int         h;
    logic [7:0] r;
    int         ex;
    int         ey;
    logic       ev;
  } probe_t;

  probe_t probes [6];

  video_sync_receiver #(.POS_W(PW), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .red(red), .green(green), .blue(blue), .x(x), .y(y), .pixel_valid(pixel_valid),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .frame_start(frame_start), .h_total(h_total), .v_total(v_total),
    .h_active(h_active), .v_active(v_active), .locked(locked), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 309 x 262 raster, 256x240 active from (40,10), vsync rising at line 254 + vs_off.
  task automatic step_px(input logic [7:0] pr);
    int p;
    p = vc * 309 + hc;
    hsync      = (hc < 20);
    display_on = (hc >= 40 && hc < 296 && vc >= 10 && vc < 250);
    vsync      = (p >= 254 * 309 + vs_off) && (p < 257 * 309 + vs_off);
    red        = pr;
    green      = 8'(vc);
    blue       = 8'h3C;
    @(posedge clk);
    #1;
    hc++;
    if (hc == hlen) begin
      hc = 0;
      hlen = 309;
      vc++;
      if (vc == 262) vc = 0;
    end
  endtask

  task automatic step();
    step_px(8'(hc));
  endtask

  task automatic run_until(input int v, input int h);
    int n;
    n = 0;
    while (!(vc == v && hc == h)) begin
      step();
      n++;
      if (n > 200000) begin
        failed++;
        compared++;
        $display("FAIL run_until: position (%0d,%0d) not reached", v, h);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $fatal(1, "raster position unreachable");
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_pixel_valid"}, pixel_valid, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_h_total"}, h_total, 0);
    check({tag, "_v_total"}, v_total, 0);
    check({tag, "_h_active"}, h_active, 0);
    check({tag, "_v_active"}, v_active, 0);
    check({tag, "_red_out"}, red_out, 0);
  endtask

  initial begin
    probes[0] = '{v: 10,  h: 40,  r: 8'h11, ex: 0,   ey: 0,   ev: 1'b1};
    probes[1] = '{v: 10,  h: 295, r: 8'h22, ex: 255, ey: 0,   ev: 1'b1};
    probes[2] = '{v: 43,  h: 57,  r: 8'hA5, ex: 17,  ey: 33,  ev: 1'b1};
    probes[3] = '{v: 100, h: 39,  r: 8'h33, ex: 0,   ey: 0,   ev: 1'b0};
    probes[4] = '{v: 249, h: 295, r: 8'h44, ex: 255, ey: 239, ev: 1'b1};
    probes[5] = '{v: 250, h: 40,  r: 8'h55, ex: 0,   ey: 0,   ev: 1'b0};

    reset = 1'b1;
    hsync = 1'b0; vsync = 1'b0; display_on = 1'b0;
    red = 8'd0; green = 8'd0; blue = 8'd0;
    hc = 0; vc = 200; hlen = 309; vs_off = 100;

    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;

    // Nominal acquisition: lock on the third vsync rise after reset.
    for (int k = 1; k <= 3; k++) begin
      run_until(254, 100);
      step();
      if (k == 3) check("locked_before_3rd_vs", locked, 0);
      step();
      check($sformatf("frame_start_vs%0d", k), frame_start, 1);
      check($sformatf("locked_after_vs%0d", k), locked, (k == 3) ? 1 : 0);
      if (k == 2) begin
        check("v_total_nominal", v_total, 262);
        check("v_active_nominal", v_active, 240);
      end
      step();
      check($sformatf("frame_start_end_vs%0d", k), frame_start, 0);
    end

    // Pixel position and data alignment probes.
    for (int i = 0; i < 6; i++) begin
      run_until(probes[i].v, probes[i].h);
      step_px(probes[i].r);
      step();
      check($sformatf("probe%0d_valid", i), pixel_valid, probes[i].ev);
      if (probes[i].ev) begin
        check($sformatf("probe%0d_x", i), x, probes[i].ex);
        check($sformatf("probe%0d_y", i), y, probes[i].ey);
        check($sformatf("probe%0d_red", i), red_out, probes[i].r);
        check($sformatf("probe%0d_green", i), green_out, probes[i].v);
        check($sformatf("probe%0d_blue", i), blue_out, 8'h3C);
      end
    end
    check("h_total_nominal", h_total, 309);
    check("h_active_nominal", h_active, 256);
    check("v_total_locked", v_total, 262);
    check("locked_steady", locked, 1);

    // One short line while locked.
    run_until(251, 0);
    hlen = 300;
    run_until(252, 0);
    step();
    check("glitch_locked_at_rise", locked, 1);
    step();
    check("glitch_locked_drop", locked, 0);
    check("glitch_err_count", err_count, 1);
    check("glitch_h_total", h_total, 300);

    run_until(254, 100);
    step();
    step();
    check("glitch_search_exit", locked, 0);
    vs_off = 0;

    // vsync and hsync rising together.
    run_until(254, 0);
    step();
    check("coinc_fs_before", frame_start, 0);
    step();
    check("coinc_fs", frame_start, 1);
    check("coinc_v_total", v_total, 262);
    check("coinc_v_active", v_active, 240);
    check("coinc_y", y, 0);
    check("coinc_locked_measure", locked, 0);
    step();
    check("coinc_fs_single", frame_start, 0);

    run_until(254, 0);
    step();
    step();
    check("relock", locked, 1);
    check("relock_err_count", err_count, 1);

    // Overlong line saturates the period measurement.
    run_until(50, 0);
    hlen = 600;
    run_until(51, 0);
    step();
    step();
    check("sat_h_total", h_total, 511);
    check("sat_h_active", h_active, 256);
    check("sat_locked", locked, 0);
    check("sat_err_count", err_count, 2);

    // One-cycle reset in the middle of a frame.
    run_until(100, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("midreset");
    run_until(254, 0);
    step();
    step();
    check("midreset_partial_v_total", v_total, 155);
    check("midreset_partial_v_active", v_active, 150);
    check("midreset_locked1", locked, 0);
    run_until(254, 0);
    step();
    step();
    check("midreset_full_v_total", v_total, 262);
    check("midreset_full_v_active", v_active, 240);
    check("midreset_locked2", locked, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
